// File: rtl/seq_multiplier_pkg.sv
// Shared types for the sequential shift-and-add / Booth multiplier.
package seq_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    MODE_UNSIGNED = 1'b0,
    MODE_SIGNED   = 1'b1
  } mode_t;

endpackage

// File: rtl/multiplier_step.sv
// One partial-product step: unsigned add-and-shift or radix-2 Booth step.
// Purely combinational; the top level sequences N of these.
module multiplier_step
  import seq_multiplier_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N:0]   i_a,
  input  logic [N-1:0] i_q,
  input  logic         i_q_m1,
  input  logic [N-1:0] i_m,
  input  mode_t        i_mode,
  output logic [N:0]   o_a,
  output logic [N-1:0] o_q,
  output logic         o_q_m1
);

  logic [N:0] w_m_ext;
  logic [N:0] w_usum;
  logic [N:0] w_ssum;

  // a carries one guard bit so the most negative multiplicand cannot overflow
  assign w_m_ext = {i_m[N-1], i_m};

  // unsigned: carry out of the N-bit add lands in the top of the sum
  assign w_usum = {1'b0, i_a[N-1:0]} + (i_q[0] ? {1'b0, i_m} : '0);

  // Booth recoding on {q[0], q_m1}
  always_comb begin
    w_ssum = i_a;
    case ({i_q[0], i_q_m1})
      2'b01:   w_ssum = i_a + w_m_ext;
      2'b10:   w_ssum = i_a - w_m_ext;
      default: w_ssum = i_a;
    endcase
  end

  // right shift of {a, q, q_m1}: logical for unsigned, arithmetic for signed
  always_comb begin
    o_q_m1 = i_q[0];
    if (i_mode == MODE_SIGNED) begin
      o_a = {w_ssum[N], w_ssum[N:1]};
      o_q = {w_ssum[0], i_q[N-1:1]};
    end else begin
      o_a = {1'b0, w_usum[N:1]};
      o_q = {w_usum[0], i_q[N-1:1]};
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential multiplier: N steps per product, valid/ready on both sides,
// synchronous abort. Operands are captured on accept; product held in DONE.
//
// state | meaning
// IDLE  | waiting for operands, in_ready = 1
// RUN   | one step per clock, count tracks remaining steps
// DONE  | product valid, held until out_ready; can restart on same edge
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           signed_mode,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  input  logic           abort,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  state_t        r_state;
  mode_t         r_mode;
  logic [N-1:0]  r_m;
  logic [N:0]    r_a;
  logic [N-1:0]  r_q;
  logic          r_q_m1;
  logic [CW-1:0] r_count;
  logic          r_out_valid;

  logic [N:0]    w_a_next;
  logic [N-1:0]  w_q_next;
  logic          w_q_m1_next;
  logic          w_accept;

  multiplier_step #(.N(N)) u_step (
    .i_a    (r_a),
    .i_q    (r_q),
    .i_q_m1 (r_q_m1),
    .i_m    (r_m),
    .i_mode (r_mode),
    .o_a    (w_a_next),
    .o_q    (w_q_next),
    .o_q_m1 (w_q_m1_next)
  );

  // ready in IDLE, or in DONE when the current product is taken this cycle
  assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign product   = {r_a[N-1:0], r_q};

  // FSM, step counter and operand/partial-product registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_mode      <= MODE_UNSIGNED;
      r_m         <= '0;
      r_a         <= '0;
      r_q         <= '0;
      r_q_m1      <= 1'b0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
    end else if (abort) begin
      // abort wins over any accept presented in the same cycle
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_m     <= multiplicand;
            r_q     <= multiplier;
            r_a     <= '0;
            r_q_m1  <= 1'b0;
            r_mode  <= mode_t'(signed_mode);
            r_count <= CW'(N - 1);
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a    <= w_a_next;
          r_q    <= w_q_next;
          r_q_m1 <= w_q_m1_next;
          if (r_count == '0) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_count <= r_count - CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (in_valid) begin
              r_m     <= multiplicand;
              r_q     <= multiplier;
              r_a     <= '0;
              r_q_m1  <= 1'b0;
              r_mode  <= mode_t'(signed_mode);
              r_count <= CW'(N - 1);
              r_state <= RUN;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at N = 4, plus a full operand sweep
// against an arithmetic reference.
module tb_seq_multiplier;

  localparam int N = 4;

  logic           clock = 1'b0;
  logic           reset_n;
  logic           in_valid;
  logic           in_ready;
  logic           signed_mode;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic           abort;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] product;

  int n_pass  = 0;
  int n_total = 0;

  seq_multiplier #(.N(N)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .signed_mode  (signed_mode),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .abort        (abort),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // present one operation, wait for out_valid, then drain it
  task automatic do_op(input logic s, input logic [3:0] m, input logic [3:0] q,
                       output logic [7:0] p, output int lat, output logic rdy);
    out_ready    = 1'b0;
    signed_mode  = s;
    multiplicand = m;
    multiplier   = q;
    in_valid     = 1'b1;
    tick();
    rdy      = in_ready;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    p = product;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    n_total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 8'h00)
      $display("FAIL reset: in_ready=%b out_valid=%b product=%h, want 1 0 00",
               in_ready, out_valid, product);
    else n_pass++;
    reset_n = 1'b1;
    tick();
    n_total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL post_reset_idle: in_ready=%b out_valid=%b, want 1 0",
               in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_unsigned();
    logic [7:0] p; int lat; logic rdy;
    do_op(1'b0, 4'hF, 4'hF, p, lat, rdy);
    n_total++;
    if (rdy !== 1'b0) $display("FAIL u15x15_in_ready: got %b want 0", rdy);
    else n_pass++;
    n_total++;
    if (lat !== 4) $display("FAIL u15x15_latency: got %0d want 4", lat);
    else n_pass++;
    n_total++;
    if (p !== 8'hE1) $display("FAIL u15x15_product: got %h want e1", p);
    else n_pass++;
  endtask

  task automatic test_signed();
    logic [7:0] p; int lat; logic rdy;
    do_op(1'b1, 4'h8, 4'h8, p, lat, rdy);
    n_total++;
    if (p !== 8'h40) $display("FAIL s_m8xm8: got %h want 40", p);
    else n_pass++;
    do_op(1'b1, 4'h8, 4'h7, p, lat, rdy);
    n_total++;
    if (p !== 8'hC8) $display("FAIL s_m8x7: got %h want c8", p);
    else n_pass++;
    do_op(1'b1, 4'h3, 4'hB, p, lat, rdy);
    n_total++;
    if (p !== 8'hF1) $display("FAIL s_3xm5: got %h want f1", p);
    else n_pass++;
    n_total++;
    if (lat !== 4) $display("FAIL s_latency: got %0d want 4", lat);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int c;
    out_ready    = 1'b1;
    signed_mode  = 1'b0;
    multiplicand = 4'd6;
    multiplier   = 4'd7;
    in_valid     = 1'b1;
    tick();
    in_valid = 1'b0;
    c = 0;
    while (!out_valid && c < 20) begin
      tick();
      c++;
    end
    n_total++;
    if (product !== 8'h2A || in_ready !== 1'b1)
      $display("FAIL b2b_first: product=%h in_ready=%b, want 2a 1", product, in_ready);
    else n_pass++;
    signed_mode  = 1'b1;
    multiplicand = 4'hF;
    multiplier   = 4'hF;
    in_valid     = 1'b1;
    tick();
    in_valid = 1'b0;
    c = 1;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL b2b_restart: out_valid=%b want 0", out_valid);
    else n_pass++;
    while (!out_valid && c < 20) begin
      tick();
      c++;
    end
    n_total++;
    if (c !== 5) $display("FAIL b2b_spacing: got %0d cycles want 5", c);
    else n_pass++;
    n_total++;
    if (product !== 8'h01) $display("FAIL b2b_second: got %h want 01", product);
    else n_pass++;
    tick();
    out_ready = 1'b0;
    n_total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL b2b_to_idle: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int c;
    out_ready    = 1'b0;
    signed_mode  = 1'b0;
    multiplicand = 4'd9;
    multiplier   = 4'd2;
    in_valid     = 1'b1;
    tick();
    multiplicand = 4'd1;
    multiplier   = 4'd1;
    c = 0;
    while (!out_valid && c < 20) begin
      tick();
      c++;
    end
    for (int i = 0; i < 10; i++) begin
      n_total++;
      if (out_valid !== 1'b1 || product !== 8'h12 || in_ready !== 1'b0)
        $display("FAIL backpressure_hold[%0d]: out_valid=%b product=%h in_ready=%b, want 1 12 0",
                 i, out_valid, product, in_ready);
      else n_pass++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL backpressure_ready: got %b want 1", in_ready);
    else n_pass++;
    tick();
    out_ready = 1'b0;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL backpressure_release: out_valid=%b want 0", out_valid);
    else n_pass++;
  endtask

  // kind 0 = abort, kind 1 = reset, both asserted at RUN cycle 2
  task automatic test_cancel(input int kind);
    logic [7:0] p; int lat; logic rdy; int seen;
    out_ready    = 1'b0;
    signed_mode  = 1'b0;
    multiplicand = 4'd7;
    multiplier   = 4'd7;
    in_valid     = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    if (kind == 0) begin
      abort    = 1'b1;
      in_valid = 1'b1;
    end else begin
      reset_n = 1'b0;
    end
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    reset_n  = 1'b1;
    n_total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL cancel%0d_idle: in_ready=%b out_valid=%b, want 1 0", kind, in_ready, out_valid);
    else n_pass++;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen++;
    end
    n_total++;
    if (seen !== 0) $display("FAIL cancel%0d_no_valid: out_valid cycles=%0d want 0", kind, seen);
    else n_pass++;
    do_op(1'b0, 4'd5, 4'd3, p, lat, rdy);
    n_total++;
    if (p !== 8'h0F || lat !== 4)
      $display("FAIL cancel%0d_next_op: product=%h latency=%0d, want 0f 4", kind, p, lat);
    else n_pass++;
  endtask

  task automatic test_abort_done();
    int c;
    out_ready    = 1'b0;
    signed_mode  = 1'b0;
    multiplicand = 4'd2;
    multiplier   = 4'd3;
    in_valid     = 1'b1;
    tick();
    in_valid = 1'b0;
    c = 0;
    while (!out_valid && c < 20) begin
      tick();
      c++;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL abort_done: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    else n_pass++;
  endtask

  task automatic test_sweep();
    logic [7:0] p, e; int lat; logic rdy;
    logic signed [3:0] sm, sq;
    int prod;
    for (int s = 0; s < 2; s++) begin
      for (int m = 0; m < 16; m++) begin
        for (int q = 0; q < 16; q++) begin
          do_op(s[0], m[3:0], q[3:0], p, lat, rdy);
          sm = m[3:0];
          sq = q[3:0];
          prod = (s == 1) ? int'(sm) * int'(sq) : m * q;
          e = prod[7:0];
          n_total++;
          if (p !== e || lat !== 4)
            $display("FAIL sweep s=%0d %0d*%0d: product=%h latency=%0d, want %h 4",
                     s, m, q, p, lat, e);
          else n_pass++;
        end
      end
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    in_valid     = 1'b0;
    signed_mode  = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    abort        = 1'b0;
    out_ready    = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_back_to_back();
    test_backpressure();
    test_cancel(0);
    test_cancel(1);
    test_abort_done();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
